// File: rtl/key_event_queue.sv
// Debounced push-button encoder feeding a small key-event FIFO.
// Latency: a press first registered at edge N is queued at edge N+DEBOUNCE; pops take effect at the next edge.
// Backpressure: a full FIFO drops new events and sets a sticky overflow flag; a same-edge pop frees room for the push.
// Optional feature: define KEY_REPEAT_EN to auto-repeat a held key (REPEAT_DELAY, then every REPEAT_PERIOD cycles).
module key_event_queue #(
  parameter int DEBOUNCE      = 2,
  parameter int DEPTH         = 4,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [20:0] pb,
  input  logic        pop,
  output logic [4:0]  key,
  output logic        valid,
  output logic [4:0]  count,
  output logic        overflow
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  // Reject configurations the counters and pointers cannot represent.
  if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
    $error("key_event_queue: DEBOUNCE must be 1..15");
  end
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("key_event_queue: DEPTH must be a power of 2 in 2..16");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("key_event_queue: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;

  logic [20:0]   pb_q;
  logic [4:0]    code;
  logic          any;
  state_t        state_q;
  logic [3:0]    stab_q;
  logic [4:0]    cand_q;
  logic          accept;
  logic          rpt_push;
  logic          push;
  logic [4:0]    push_code;

  logic [4:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [4:0]    cnt_q;
  logic          ovf_q;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          drop;

  // Input register: every decision below looks only at this sampled copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pb_q <= '0;
    else       pb_q <= pb;
  end

  // Priority encoder: highest pressed button wins.
  always_comb begin
    code = 5'd0;
    for (int i = 0; i < 21; i++) begin
      if (pb_q[i]) code = 5'(i);
    end
  end

  assign any = |pb_q;

  // Acceptance: the IDLE sample counts as the first stable sample, so ARM
  // needs DEBOUNCE-1 further matching samples.
  always_comb begin
    accept = 1'b0;
    case (state_q)
      IDLE:    accept = any && (DEBOUNCE == 1);
      ARM:     accept = any && (code == cand_q) && ((stab_q + 4'd1) >= DB_LAST);
      default: accept = 1'b0;
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam logic [15:0] RPT_DELAY  = 16'(REPEAT_DELAY);
  localparam logic [15:0] RPT_PERIOD = 16'(REPEAT_PERIOD);

  logic [15:0] rpt_q;
  logic        rpt_armed_q;
  logic [15:0] rpt_inc;

  assign rpt_inc  = rpt_q + 16'd1;
  assign rpt_push = (state_q == HELD) && any &&
                    (rpt_armed_q ? (rpt_inc == RPT_PERIOD) : (rpt_inc == RPT_DELAY));

  // Repeat timer: runs only during uninterrupted HELD; any release bounce restarts the delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_q       <= '0;
      rpt_armed_q <= 1'b0;
    end else if (state_q == HELD && any) begin
      if (rpt_push) begin
        rpt_q       <= '0;
        rpt_armed_q <= 1'b1;
      end else begin
        rpt_q <= rpt_inc;
      end
    end else begin
      rpt_q       <= '0;
      rpt_armed_q <= 1'b0;
    end
  end
`else
  assign rpt_push = 1'b0;
`endif

  assign push      = accept | rpt_push;
  // In ARM and HELD the latched candidate is the code being reported.
  assign push_code = (state_q == IDLE) ? code : cand_q;

  // Debounce FSM: IDLE -> ARM -> HELD -> REL -> IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      stab_q  <= '0;
      cand_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any) begin
            cand_q  <= code;
            stab_q  <= '0;
            state_q <= (DEBOUNCE == 1) ? HELD : ARM;
          end
        end
        ARM: begin
          if (!any) begin
            state_q <= IDLE;
          end else if (code != cand_q) begin
            cand_q <= code;
            stab_q <= '0;
          end else if (accept) begin
            state_q <= HELD;
          end else begin
            stab_q <= stab_q + 4'd1;
          end
        end
        HELD: begin
          // Code changes while still pressed are deliberately ignored.
          if (!any) begin
            state_q <= REL;
            stab_q  <= '0;
          end
        end
        REL: begin
          // The HELD sample that saw the release counts as the first quiet sample.
          if (any) begin
            state_q <= HELD;
          end else if ((stab_q + 4'd1) >= DB_LAST) begin
            state_q <= IDLE;
          end else begin
            stab_q <= stab_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign full    = (cnt_q == DEPTH_C);
  assign valid   = (cnt_q != 5'd0);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  // FIFO control: pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 5'd1;
        2'b01:   cnt_q <= cnt_q - 5'd1;
        default: cnt_q <= cnt_q;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  // FIFO storage: contents are only visible through valid-gated key, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_code;
  end

  assign key      = valid ? mem_q[rd_ptr_q] : 5'd0;
  assign count    = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Bench for key_event_queue: directed scenarios with literal expectations plus
// randomized button traffic, compared every cycle against a behavioural model.
module tb_key_event_queue;

  localparam int DEBOUNCE      = 2;
  localparam int DEPTH         = 4;
  localparam int REPEAT_DELAY  = 50;
  localparam int REPEAT_PERIOD = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [20:0] pb = '0;
  logic        pop = 1'b0;
  logic [4:0]  key;
  logic        valid;
  logic [4:0]  count;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  key_event_queue #(
    .DEBOUNCE(DEBOUNCE), .DEPTH(DEPTH),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .clk(clk), .reset(reset), .pb(pb), .pop(pop),
    .key(key), .valid(valid), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [20:0] m_pbq;
  logic [4:0]  m_q[$];
  bit          m_ovf;
  bit          m_down;      // a press has been accepted and not yet fully released
  int          m_run;       // consecutive samples of the same non-zero code before acceptance
  logic [4:0]  m_runcode;
  int          m_zrun;      // consecutive zero samples while down
  int          m_hold;      // consecutive non-zero samples while down

  function automatic logic [4:0] top_bit(input logic [20:0] v);
    logic [4:0] r = 5'd0;
    for (int i = 0; i < 21; i++) if (v[i]) r = 5'(i);
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pbq = '0; m_q.delete(); m_ovf = 0; m_down = 0;
      m_run = 0; m_runcode = '0; m_zrun = 0; m_hold = 0;
    end else begin
      bit         a;
      logic [4:0] c;
      bit         ev;
      logic [4:0] ec;
      bit         popped;
      a  = |m_pbq;
      c  = top_bit(m_pbq);
      ev = 0;
      ec = '0;
      if (!m_down) begin
        if (!a) m_run = 0;
        else if (m_run > 0 && c == m_runcode) m_run++;
        else begin m_run = 1; m_runcode = c; end
        if (a && m_run >= DEBOUNCE) begin
          ev = 1; ec = m_runcode;
          m_down = 1; m_zrun = 0; m_hold = 1; m_run = 0;
        end
      end else begin
        if (!a) begin
          m_zrun++; m_hold = 0;
          if (m_zrun >= DEBOUNCE) m_down = 0;
        end else begin
          m_zrun = 0; m_hold++;
`ifdef KEY_REPEAT_EN
          if ((m_hold - 1) >= REPEAT_DELAY &&
              ((m_hold - 1 - REPEAT_DELAY) % REPEAT_PERIOD) == 0) begin
            ev = 1; ec = m_runcode;
          end
`endif
        end
      end
      popped = pop && (m_q.size() > 0);
      if (popped) void'(m_q.pop_front());
      if (ev) begin
        if (m_q.size() < DEPTH) m_q.push_back(ec);
        else m_ovf = 1;
      end
      m_pbq = pb;
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", int'(valid), int'(m_q.size() > 0));
      chk("model_count", int'(count), m_q.size());
      chk("model_key", int'(key), (m_q.size() > 0) ? int'(m_q[0]) : 0);
      chk("model_ovf", int'(overflow), int'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(valid), 0);
    step(2);
    reset = 1'b0;
  endtask

  task automatic press(input logic [20:0] v);
    pb = v; step(3);
    pb = '0; step(3);
  endtask

  task automatic pop_expect(input string name, input int exp_key);
    chk(name, int'(key), exp_key);
    pop = 1'b1; step(1); pop = 1'b0;
  endtask

  function automatic logic [20:0] bitv(input int i);
    logic [20:0] one = 21'd1;
    return one << i;
  endfunction

  initial begin
    step(1);
    chk("reset_key", int'(key), 0);
    chk("reset_ovf", int'(overflow), 0);
    reset = 1'b0;
    chk_en = 1'b1;
    step(2);

    // Single press of button 5: queued two edges after first sample.
    pb = bitv(5);
    step(1); chk("p5_edgeN", int'(valid), 0);
    step(1); chk("p5_edgeN1", int'(valid), 0);
    step(1);
    chk("p5_valid", int'(valid), 1);
    chk("p5_key", int'(key), 5);
    chk("p5_count", int'(count), 1);
    step(7); pb = '0; step(3);
    chk("p5_one_entry", int'(count), 1);
    pop = 1'b1; step(1); pop = 1'b0;
    chk("p5_pop_valid", int'(valid), 0);
    chk("p5_pop_key", int'(key), 0);

    // One-cycle glitch is filtered, then a clean press is accepted normally.
    pb = bitv(3); step(1); pb = '0; step(4);
    chk("glitch_count", int'(count), 0);
    pb = bitv(6); step(3);
    chk("after_glitch_key", int'(key), 6);
    pb = '0; step(3);
    pop = 1'b1; step(1); pop = 1'b0;

    // Overflow: five presses into a four-deep queue.
    press(bitv(1)); press(bitv(2)); press(bitv(3)); press(bitv(4)); press(bitv(7));
    chk("ovf_count", int'(count), 4);
    chk("ovf_flag", int'(overflow), 1);
    pop_expect("ovf_pop1", 1); pop_expect("ovf_pop2", 2);
    pop_expect("ovf_pop3", 3); pop_expect("ovf_pop4", 4);
    chk("ovf_empty", int'(valid), 0);
    chk("ovf_sticky", int'(overflow), 1);

    // Full queue, push and pop on the same edge.
    do_reset();
    press(bitv(1)); press(bitv(2)); press(bitv(3)); press(bitv(4));
    pb = bitv(9); step(2);
    pop = 1'b1; step(1); pop = 1'b0;
    chk("fullpp_count", int'(count), 4);
    chk("fullpp_ovf", int'(overflow), 0);
    pb = '0; step(3);
    pop_expect("fullpp_pop1", 2); pop_expect("fullpp_pop2", 3);
    pop_expect("fullpp_pop3", 4); pop_expect("fullpp_pop4", 9);

    // Two buttons at once: highest index wins.
    pb = bitv(16) | bitv(9); step(3);
    chk("multi_key", int'(key), 16);
    chk("multi_count", int'(count), 1);
    pb = '0; step(3);
    pop = 1'b1; step(1); pop = 1'b0;

    // Reset in the middle of ARM discards the press; a still-held key re-debounces.
    pb = bitv(12); step(2);
    do_reset();
    chk("rstarm_count", int'(count), 0);
    step(1); chk("rstarm_m", int'(count), 0);
    step(1); chk("rstarm_m1", int'(count), 0);
    step(1);
    chk("rstarm_repress_count", int'(count), 1);
    chk("rstarm_repress_key", int'(key), 12);
    pb = '0; step(3);
    pop = 1'b1; step(1); pop = 1'b0;

`ifdef KEY_REPEAT_EN
    begin
      int offs[$];
      do_reset();
      pop = 1'b1;
      pb = bitv(2);
      for (int i = 1; i <= 90; i++) begin
        step(1);
        if (valid) offs.push_back(i - 1);
        if (i == 80) pb = '0;
      end
      pop = 1'b0;
      chk("rpt_events", offs.size(), 4);
      if (offs.size() == 4) begin
        chk("rpt_ev0", offs[0], 2);
        chk("rpt_ev1", offs[1], 52);
        chk("rpt_ev2", offs[2], 62);
        chk("rpt_ev3", offs[3], 72);
      end
    end
`endif

    // Randomized traffic against the model.
    do_reset();
    begin
      bit popen = 1'b1;
      for (int ep = 0; ep < 400; ep++) begin
        int          kind;
        int          len;
        int          gap;
        logic [20:0] v;
        kind = int'($urandom_range(0, 9));
        len  = int'($urandom_range(1, 8));
        gap  = int'($urandom_range(0, 4));
        v    = bitv(int'($urandom_range(0, 20)));
        if (kind == 0) v = v | bitv(int'($urandom_range(0, 20)));
        if ($urandom_range(0, 7) == 0) popen = ~popen;
        for (int i = 0; i < len; i++) begin
          pb  = (kind == 1 && i == len / 2) ? bitv(int'($urandom_range(0, 20))) : v;
          if (kind == 2 && i == len / 2) pb = '0;
          pop = popen && ($urandom_range(0, 2) == 0);
          step(1);
        end
        pb = '0;
        for (int i = 0; i < gap; i++) begin
          pop = popen && ($urandom_range(0, 2) == 0);
          step(1);
        end
        pop = 1'b0;
        if ($urandom_range(0, 60) == 0) begin
          pb = v;
          do_reset();
        end
      end
    end
    pb = '0; pop = 1'b0;
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
